uart_line_assembler: RTL and testbench

UART_LINE_ASSEMBLER -- requirements
Module: uart_line_assembler

---
 rtl/uart_line_assembler.sv | 122 ++++++++++++
 tb/tb_uart_line_assembler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_assembler.sv
// rtl/uart_line_assembler.sv - assembles RX FIFO bytes into terminator-delimited lines held for a consumer
// Optional UART_LINE_SKIP_EMPTY_EN: a terminator arriving on an empty line is swallowed instead of delivered.
module uart_line_assembler #(
  parameter int LINE_BYTES  = 16,
  parameter int COUNT_WIDTH = 8,
  localparam int IDX_W = $clog2(LINE_BYTES),
  localparam int LEN_W = $clog2(LINE_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifoEmpty,
  output logic                   fifoReadReq,
  input  logic                   fifoReadAck,
  input  logic [10:0]            fifoData,
  input  logic [7:0]             terminator,
  output logic                   lineValid,
  input  logic                   lineAck,
  input  logic [IDX_W-1:0]       lineIndex,
  output logic [7:0]             lineData,
  output logic [LEN_W-1:0]       lineLength,
  output logic                   lineError,
  output logic                   lineTruncated,
  output logic [COUNT_WIDTH-1:0] errorCount
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       count_q, count_d;
  logic                   line_error_q, line_error_d;
  logic                   line_truncated_q, line_truncated_d;
  logic [COUNT_WIDTH-1:0] error_count_q, error_count_d;
  logic [7:0]             line_mem [LINE_BYTES];

  logic [7:0] rx_byte;
  logic       rx_flag;
  logic       accept;
  logic       is_term;
  logic       at_last;
  logic       skip_empty;
  logic       wr_en;

  assign rx_byte = fifoData[7:0];
  assign rx_flag = fifoData[10] | fifoData[9];
  assign accept  = (state_q == FILL) & fifoReadAck;
  assign is_term = (rx_byte == terminator);
  assign at_last = (count_q == LEN_W'(LINE_BYTES - 1));

`ifdef UART_LINE_SKIP_EMPTY_EN
  assign skip_empty = (count_q == '0);
`else
  assign skip_empty = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= FILL;
      count_q          <= '0;
      line_error_q     <= 1'b0;
      line_truncated_q <= 1'b0;
      error_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      line_error_q     <= line_error_d;
      line_truncated_q <= line_truncated_d;
      error_count_q    <= error_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (accept && ((is_term && !skip_empty) || (!is_term && at_last))) state_d = HOLD;
      HOLD: if (lineAck) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    fifoReadReq = 1'b0;
    lineValid   = 1'b0;
    if (rst && state_q == FILL) fifoReadReq = ~fifoEmpty;
    if (state_q == HOLD) lineValid = 1'b1;
  end

  // A swallowed empty-line terminator still counts as a flagged entry but must not taint the next line.
  always_comb begin
    count_d          = count_q;
    line_error_d     = line_error_q;
    line_truncated_d = line_truncated_q;
    error_count_d    = error_count_q;
    wr_en            = 1'b0;
    if (accept) begin
      if (rx_flag && error_count_q != '1) error_count_d = error_count_q + 1'b1;
      if (!is_term) begin
        wr_en        = 1'b1;
        count_d      = count_q + 1'b1;
        line_error_d = line_error_q | rx_flag;
        if (at_last) line_truncated_d = 1'b1;
      end else if (!skip_empty) begin
        line_error_d = line_error_q | rx_flag;
      end
    end
    if (state_q == HOLD && lineAck) begin
      count_d          = '0;
      line_error_d     = 1'b0;
      line_truncated_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_mem[count_q[IDX_W-1:0]] <= rx_byte;
  end

  assign lineData      = line_mem[lineIndex];
  assign lineLength    = count_q;
  assign lineError     = line_error_q;
  assign lineTruncated = line_truncated_q;
  assign errorCount    = error_count_q;

endmodule

// File: tb/tb_uart_line_assembler.sv
// tb/tb_uart_line_assembler.sv - scoreboard bench for uart_line_assembler with a stream-level line model
module tb_uart_line_assembler;
  localparam int LB = 16;
  localparam int CW = 8;
  localparam int IW = $clog2(LB);
  localparam int LW = $clog2(LB + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifoEmpty = 1'b1;
  logic          fifoReadReq;
  logic          fifoReadAck = 1'b0;
  logic [10:0]   fifoData = '0;
  logic [7:0]    terminator = 8'h0A;
  logic          lineValid;
  logic          lineAck = 1'b0;
  logic [IW-1:0] lineIndex = '0;
  logic [7:0]    lineData;
  logic [LW-1:0] lineLength;
  logic          lineError;
  logic          lineTruncated;
  logic [CW-1:0] errorCount;

  always #20 clk = ~clk;

  uart_line_assembler #(.LINE_BYTES(LB), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifoEmpty(fifoEmpty), .fifoReadReq(fifoReadReq),
    .fifoReadAck(fifoReadAck), .fifoData(fifoData), .terminator(terminator),
    .lineValid(lineValid), .lineAck(lineAck), .lineIndex(lineIndex), .lineData(lineData),
    .lineLength(lineLength), .lineError(lineError), .lineTruncated(lineTruncated),
    .errorCount(errorCount)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the byte stream is split into lines as it is pushed, independent of handshake timing.
  logic [11:0] fifo_q[$];
  logic [7:0]  part_q[$];
  bit          part_err = 0;
  int          m_errcnt = 0;
  int          exp_len_q[$];
  bit          exp_err_q[$];
  bit          exp_trunc_q[$];
  logic [7:0]  exp_byte_q[$];
  bit          exp_valid = 0;
  bit          spurious = 0;
  logic [11:0] popped;

  task automatic emit(input bit extra_err, input bit trunc);
    exp_len_q.push_back(part_q.size());
    exp_err_q.push_back(part_err | extra_err);
    exp_trunc_q.push_back(trunc);
    foreach (part_q[i]) exp_byte_q.push_back(part_q[i]);
    part_q.delete();
    part_err = 0;
  endtask

  task automatic push(input logic [7:0] b, input bit par, input bit ovf);
    bit flag;
    bit closes;
    bit skip;
    flag = par | ovf;
    closes = 0;
    skip = 0;
    if (flag && m_errcnt < CMAX) m_errcnt++;
    if (b == terminator) begin
`ifdef UART_LINE_SKIP_EMPTY_EN
      skip = (part_q.size() == 0);
`endif
      if (!skip) begin
        emit(flag, 0);
        closes = 1;
      end
    end else begin
      part_q.push_back(b);
      part_err |= flag;
      if (part_q.size() == LB) begin
        emit(0, 1);
        closes = 1;
      end
    end
    fifo_q.push_back({closes, ovf, par, 1'($urandom), b});
    fifoEmpty = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", int'(n < 3000), 1);
    @(negedge clk);
    #18;
  endtask

  // FIFO driver: acks with random gaps, and occasionally pulses a flagged ack while a line is held.
  always @(negedge clk) begin
    fifoReadAck = 1'b0;
    spurious = 0;
    if (rst) begin
      if (fifoReadReq && fifo_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        fifoReadAck = 1'b1;
        fifoData = fifo_q[0][10:0];
      end else if (exp_valid && $urandom_range(0, 7) == 0) begin
        fifoReadAck = 1'b1;
        spurious = 1;
        fifoData = {2'b11, 9'($urandom)};
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (fifoReadAck && !spurious) begin
        popped = fifo_q.pop_front();
        if (popped[11]) exp_valid = 1;
        fifoEmpty = (fifo_q.size() == 0);
      end else if (lineAck && exp_valid) begin
        exp_valid = 0;
      end
    end
  end

  bit shown = 0;
  int hold_wait = 0;
  int cur_len = 0;
  bit cur_err = 0;
  bit cur_trunc = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("line_valid", int'(lineValid), int'(exp_valid));
      check("read_req", int'(fifoReadReq), int'(!exp_valid && !fifoEmpty));
      if (!exp_valid) begin
        lineAck = 1'b0;
        shown = 0;
      end else if (!shown) begin
        shown = 1;
        hold_wait = $urandom_range(0, 3);
        if (exp_len_q.size() == 0) begin
          check("line_expected", 1, 0);
        end else begin
          cur_len = exp_len_q.pop_front();
          cur_err = exp_err_q.pop_front();
          cur_trunc = exp_trunc_q.pop_front();
          check("line_length", int'(lineLength), cur_len);
          check("line_error", int'(lineError), int'(cur_err));
          check("line_truncated", int'(lineTruncated), int'(cur_trunc));
          for (int i = 0; i < cur_len; i++) begin
            lineIndex = IW'(i);
            #1;
            check("line_data", int'(lineData), int'(exp_byte_q.pop_front()));
          end
        end
      end else begin
        check("hold_length", int'(lineLength), cur_len);
        check("hold_error", int'(lineError), int'(cur_err));
        check("hold_truncated", int'(lineTruncated), int'(cur_trunc));
        if (hold_wait == 0) lineAck = 1'b1;
        else hold_wait--;
      end
    end
  end

  initial begin
    int len;
    repeat (3) @(posedge clk);
    @(negedge clk);
    fifoEmpty = 1'b0;
    #1;
    check("reset_read_req", int'(fifoReadReq), 0);
    check("reset_line_valid", int'(lineValid), 0);
    check("reset_length", int'(lineLength), 0);
    check("reset_error_count", int'(errorCount), 0);
    fifoEmpty = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;

    sync();
    push(8'h41, 0, 0); push(8'h42, 0, 0); push(8'h0A, 0, 0);
    drain();
    check("ab_error_count", int'(errorCount), 0);

    sync();
    for (int i = 0; i < 17; i++) push(8'(8'h30 + i), 0, 0);
    push(8'h0A, 0, 0);
    drain();

    sync();
    push(8'h41, 1, 0); push(8'h0A, 0, 1);
    drain();
    check("flag_error_count", int'(errorCount), 2);
    check("flag_released_error", int'(lineError), 0);

    sync();
    push(8'h0A, 0, 0);
    drain();
    check("empty_line_length", int'(lineLength), 0);

    terminator = 8'h0D;
    sync();
    for (int l = 0; l < 25; l++) begin
      len = $urandom_range(0, 20);
      for (int i = 0; i < len; i++)
        push(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      push(8'h0D, $urandom_range(0, 5) == 0, 0);
    end
    drain();
    check("random_error_count", int'(errorCount), m_errcnt);
    terminator = 8'h0A;

    sync();
    push(8'h31, 0, 0); push(8'h32, 1, 0); push(8'h33, 0, 0);
    drain();
    check("partial_length", int'(lineLength), 3);
    check("partial_error", int'(lineError), 1);
    rst = 1'b0;
    fifoEmpty = 1'b0;
    #1;
    check("midreset_line_valid", int'(lineValid), 0);
    check("midreset_length", int'(lineLength), 0);
    check("midreset_error", int'(lineError), 0);
    check("midreset_truncated", int'(lineTruncated), 0);
    check("midreset_error_count", int'(errorCount), 0);
    check("midreset_read_req", int'(fifoReadReq), 0);
    fifoEmpty = 1'b1;
    part_q.delete();
    part_err = 0;
    m_errcnt = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    sync();
    push(8'h5A, 0, 0); push(8'h0A, 0, 0);
    drain();

    sync();
    for (int i = 0; i < 300; i++) push(8'($urandom), $urandom_range(0, 1) == 0, 1);
    push(8'h0A, 0, 0);
    drain();
    check("saturated_error_count", int'(errorCount), CMAX);
    check("model_error_count", int'(errorCount), m_errcnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
